// File: rtl/mf_taps_pkg.sv
// Shared 41-tap half-sine table: round(32767 * sin(pi * k / 40)), k = 0..40.
package mf_taps_pkg;

    localparam int unsigned MF_NTAPS = 41;
    localparam int unsigned MF_CW    = 16;

    localparam logic signed [MF_CW-1:0] MF_COEFFS [MF_NTAPS] = '{
        16'sd0,     16'sd2571,  16'sd5126,  16'sd7649,  16'sd10126, 16'sd12539,
        16'sd14876, 16'sd17121, 16'sd19260, 16'sd21280, 16'sd23170, 16'sd24916,
        16'sd26509, 16'sd27938, 16'sd29196, 16'sd30273, 16'sd31163, 16'sd31862,
        16'sd32364, 16'sd32666, 16'sd32767, 16'sd32666, 16'sd32364, 16'sd31862,
        16'sd31163, 16'sd30273, 16'sd29196, 16'sd27938, 16'sd26509, 16'sd24916,
        16'sd23170, 16'sd21280, 16'sd19260, 16'sd17121, 16'sd14876, 16'sd12539,
        16'sd10126, 16'sd7649,  16'sd5126,  16'sd2571,  16'sd0
    };

endpackage

// File: rtl/msk_tx_pkg.sv
// Shared types for the MSK transmit pulse shaper.
package msk_tx_pkg;

    localparam int unsigned SPS_DEF = 20;

    typedef enum logic [0:0] {IDLE, RUN} state_e;

    // Amplitude in {-1, 0, +1}, two's complement.
    typedef logic signed [1:0] amp_t;

endpackage

// File: rtl/msk_pulse_lut.sv
// Dual-read half-sine lookup: I at idx, Q at (idx + SPS) mod 2*SPS.
module msk_pulse_lut
    import mf_taps_pkg::*;
#(
    parameter int unsigned SPS = 20,
    parameter int unsigned DW  = 16,
    parameter int unsigned PW  = $clog2(2 * SPS + 1)
) (
    input  logic [PW-1:0]        idx,
    output logic signed [DW-1:0] coef_i,
    output logic signed [DW-1:0] coef_q
);

    if (MF_NTAPS != 2 * SPS + 1) begin : g_bad_ntaps
        $error("MF_NTAPS must equal 2*SPS+1");
    end
    if (DW != MF_CW) begin : g_bad_width
        $error("DW must equal the coefficient width");
    end

    logic [PW:0] qsum;
    logic [PW:0] qwrap;

    always_comb begin
        qsum   = {1'b0, idx} + (PW + 1)'(SPS);
        qwrap  = (qsum >= (PW + 1)'(2 * SPS)) ? qsum - (PW + 1)'(2 * SPS) : qsum;
        coef_i = MF_COEFFS[idx];
        coef_q = MF_COEFFS[qwrap[PW-1:0]];
    end

endmodule

// File: rtl/msk_tx_shaper.sv
// MSK transmit shaper: even bits on I, odd bits on Q offset by T, half-sine pulses of 2T.
module msk_tx_shaper
    import msk_tx_pkg::*;
#(
    parameter int unsigned SPS = SPS_DEF,
    parameter int unsigned DW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 s_bit,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out,
    output logic                 out_valid,
    output logic                 underrun,
    output logic                 busy
);

    localparam int unsigned PW = $clog2(2 * SPS + 1);
    localparam logic [PW-1:0] PH_Q    = PW'(SPS);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * SPS - 1);

    function automatic logic signed [DW-1:0] scale(amp_t a, logic signed [DW-1:0] c);
        unique case (a)
            2'sb01:  return c;
            2'sb11:  return -c;
            default: return '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    amp_t                ai_q, ai_d, aq_q, aq_d, ld_amp;
    logic signed [DW-1:0] i_q, q_q, coef_i, coef_q;
    logic                ov_q, un_q, un_d;
    logic                bnd_i, bnd_q, accept;

    msk_pulse_lut #(
        .SPS (SPS),
        .DW  (DW),
        .PW  (PW)
    ) u_lut (
        .idx    (phase_q),
        .coef_i (coef_i),
        .coef_q (coef_q)
    );

    assign bnd_i   = (phase_q == '0);
    assign bnd_q   = (phase_q == PH_Q);
    assign s_ready = rst_n & en & ((state_q == IDLE) | bnd_i | bnd_q);
    assign accept  = s_valid & s_ready;
    assign ld_amp  = s_bit ? 2'sb01 : 2'sb11;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ai_d    = ai_q;
        aq_d    = aq_q;
        un_d    = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    phase_d = '0;
                    if (s_valid) begin
                        ai_d    = ld_amp;
                        aq_d    = '0;
                        phase_d = PW'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
                    if (bnd_i) begin
                        ai_d = accept ? ld_amp : '0;
                        // Stream ends cleanly only once Q has no pulse in flight.
                        if (!s_valid) begin
                            if (aq_q == '0) begin
                                state_d = IDLE;
                                phase_d = '0;
                            end else begin
                                un_d = 1'b1;
                            end
                        end
                    end
                    if (bnd_q) begin
                        aq_d = accept ? ld_amp : '0;
                        un_d = !s_valid;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            ai_q    <= '0;
            aq_q    <= '0;
            i_q     <= '0;
            q_q     <= '0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ai_q    <= ai_d;
            aq_q    <= aq_d;
            ov_q    <= en;
            un_q    <= un_d;
            if (en) begin
                i_q <= scale(ai_d, coef_i);
                q_q <= scale(aq_d, coef_q);
            end
        end
    end

    assign i_out     = i_q;
    assign q_out     = q_q;
    assign out_valid = ov_q;
    assign underrun  = un_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_msk_tx_shaper.sv
// Scoreboard bench for msk_tx_shaper: stimulus pushes expected samples, monitor pops on out_valid.
module tb_msk_tx_shaper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic s_bit = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic out_valid;
    logic underrun;
    logic busy;

    always #5 clk = ~clk;

    msk_tx_shaper #(
        .SPS (20),
        .DW  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .s_bit     (s_bit),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .underrun  (underrun),
        .busy      (busy)
    );

    // Hand-rounded 32767*sin(pi*k/40).
    int ht [0:40] = '{
        0, 2571, 5126, 7649, 10126, 12539, 14876, 17121, 19260, 21280, 23170,
        24916, 26509, 27938, 29196, 30273, 31163, 31862, 32364, 32666, 32767,
        32666, 32364, 31862, 31163, 30273, 29196, 27938, 26509, 24916, 23170,
        21280, 19260, 17121, 14876, 12539, 10126, 7649, 5126, 2571, 0
    };

    typedef struct {
        int i;
        int q;
        int u;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic en_q = 1'b0;
    logic rst_q = 1'b0;
    logic mon_on = 1'b0;
    int   last_i = 0;
    int   last_q = 0;

    task automatic chk(input string name, input logic signed [31:0] got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        en_q  <= en & rst_n;
        rst_q <= ~rst_n;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("out_valid_timing", out_valid, int'(en_q));
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("i_out", i_out, mon_e.i);
                    chk("q_out", q_out, mon_e.q);
                    chk("underrun", underrun, mon_e.u);
                end
            end else begin
                chk("i_hold", i_out, rst_q ? 0 : last_i);
                chk("q_hold", q_out, rst_q ? 0 : last_q);
                chk("underrun_idle", underrun, 0);
            end
            last_i = int'(i_out);
            last_q = int'(q_out);
        end
    end

    // Expected sample at strobe k for each directed scenario.
    function automatic exp_t expect_at(input int s, input int k);
        exp_t r;
        r.i = 0;
        r.q = 0;
        r.u = 0;
        case (s)
            0: begin // single +1 bit
                if (k < 40) r.i = ht[k];
                r.u = int'(k == 20);
            end
            1: begin // bits 1,0,1,1 back to back, then stream ends
                if (k < 80) r.i = ht[k % 40];
                if (k >= 20 && k < 60) r.q = -ht[k - 20];
                else if (k >= 60 && k < 100) r.q = ht[k - 60];
                r.u = int'(k == 80 || k == 100);
            end
            default: begin // bits 1,-,0,1 with the first Q slot missed
                if (k < 40) r.i = ht[k];
                else if (k < 80) r.i = -ht[k - 40];
                if (k >= 60 && k < 100) r.q = ht[k - 60];
                r.u = int'(k == 20 || k == 80 || k == 100);
            end
        endcase
        return r;
    endfunction

    task automatic drive(input logic e, input logic v, input logic b);
        @(negedge clk);
        en      = e;
        s_valid = v;
        s_bit   = b;
    endtask

    task automatic run(input int s, input int nk, input int gap,
                       input logic [7:0] vm, input logic [7:0] bm);
        for (int k = 0; k <= nk; k++) begin
            logic v;
            logic b;
            v = 1'b0;
            b = 1'b0;
            if (k % 20 == 0) begin
                v = vm[k / 20];
                b = bm[k / 20];
            end
            drive(1'b1, v, b);
            sb.push_back(expect_at(s, k));
            #1;
            chk("s_ready", s_ready, int'(k % 20 == 0));
            chk("busy_run", busy, int'(k != 0));
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'b0);
                #1;
                chk("s_ready_gap", s_ready, 0);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        s_valid = 1'b1;
        s_bit   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_s_ready", s_ready, 0);
            chk("rst_i_out", i_out, 0);
            chk("rst_q_out", q_out, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
        end
        mon_on  = 1'b1;
        rst_n   = 1'b1;
        en      = 1'b0;
        s_valid = 1'b0;

        run(0, 40, 0, 8'b0000_0001, 8'b0000_0001);
        run(1, 120, 0, 8'b0000_1111, 8'b0000_1101);
        run(0, 40, 3, 8'b0000_0001, 8'b0000_0001);
        run(2, 120, 0, 8'b0000_1101, 8'b0000_1001);

        for (int k = 0; k <= 15; k++) begin
            drive(1'b1, k == 0, 1'b1);
            sb.push_back(expect_at(0, k));
        end
        @(negedge clk);
        rst_n   = 1'b0;
        en      = 1'b1;
        s_valid = 1'b1;
        s_bit   = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_i_out", i_out, 0);
        chk("midrst_q_out", q_out, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        rst_n   = 1'b1;
        en      = 1'b0;
        s_valid = 1'b0;
        run(0, 40, 0, 8'b0000_0001, 8'b0000_0001);

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
